chr_pixel_pipe: RTL and testbench
=================================

Name: chr_pixel_pipe

Overview:
Parametrised glyph-fetch and pixel-serialiser for the text-mode display path. It accepts one character cell per handshake (code, glyph row and attributes) and issues a glyph-ROM address. It captures the returned row bits and shifts them out one pixel per clock as a resolved colour index. Background/foreground colour, cursor inversion and blink are applied on the way. It sits between the text-buffer scanner and the VGA colour DAC stage.

Parameters:
GLYPH_W, 8, pixels per glyph row (ROM data width); must be >= 3
GLYPH_H, 16, rows per glyph
CHAR_BASE, 32, character code stored at ROM glyph index 0
NUM_GLYPHS, 96, glyphs held in ROM
REPL_IDX, 0, glyph index substituted for out-of-range codes
COLOR_W, 4, colour index width
ROW_W, 4, width of row input; must be >= clog2(GLYPH_H)
ADDR_W, clog2(NUM_GLYPHS*GLYPH_H), ROM address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
chr_valid  in  1  cell request valid
chr_ready  out  1  block can accept a cell this cycle
chr_val  in  8  character code
row  in  ROW_W  glyph row within cell
fg  in  COLOR_W  foreground colour index
bg  in  COLOR_W  background colour index
cursor  in  1  cell holds the cursor
cursor_phase  in  1  cursor visible phase
blink  in  1  cell blink attribute
blink_phase  in  1  blink visible phase
rom_addr  out  ADDR_W  glyph ROM address (registered)
rom_data  in  GLYPH_W  glyph ROM row; valid one cycle after rom_addr changes
pix_valid  out  1  pix_color/pix_on hold a live pixel
pix_on  out  1  resolved pixel is foreground
pix_color  out  COLOR_W  resolved colour index

Behaviour:
- Reset: all stage valids 0, rom_addr 0, pix_valid 0, pix_on 0, pix_color 0, bit counter 0. chr_ready is 0 while rst is high. Reset mid-shift aborts the cell; no further pixels appear.
- chr_ready = !rst & !A_valid & !B_valid. Accept = chr_valid & chr_ready.
- Index: idx = chr_val - CHAR_BASE, computed at >= 9 bits with no 8-bit wrap. If chr_val < CHAR_BASE or chr_val >= CHAR_BASE+NUM_GLYPHS, idx = REPL_IDX.
- Row handling: if row >= GLYPH_H, row is treated as 0 for the address and the row is flagged blank.
- On the accept edge: rom_addr <= idx*GLYPH_H + row; stage A captures fg, bg, blank and cursor & cursor_phase. It also captures the blink kill term, blink & !blink_phase. Phases are therefore fixed for the whole cell. A_valid <= 1.
- Edge after A_valid: stage B captures rom_data (forced all-zero if blank) and the attributes. B_valid <= 1, A_valid <= 0.
- Shifter S: loads from B when S is idle or on the edge of its last pixel (count = GLYPH_W-1). B_valid <= 0 on load. If B is empty at that edge, S goes idle and pix_valid <= 0.
- Pixel order: MSB first; bit GLYPH_W-1 is leftmost.
- Resolution per pixel (registered): on = (bit ^ inv) & !kill; pix_on <= on; pix_color <= on ? fg : bg; pix_valid <= 1.
- Latency: accept at edge E0 gives the first pixel on the outputs after E3 when S is idle.
- Throughput: back-to-back cells yield a continuous pixel stream with no gap cycles.
- Simultaneous load into S and B->... : a B load and a new accept never coincide, because ready requires B empty.
- Counter wraps GLYPH_W-1 -> 0 on each load.

Test Plan:
- Reset: rst held 3 cycles -> pix_valid=0, pix_color=0, rom_addr=0, chr_ready=0; chr_ready=1 the cycle after rst falls.
- Single cell 0x41, row 5, fg=0xF, bg=0x1, ROM model returns 0x18 -> rom_addr=33*16+5=533; after E3, pix_on = 0,0,0,1,1,0,0,0 and pix_color = 1,1,1,F,F,1,1,1; then pix_valid=0.
- Back-to-back: 4 cells offered with chr_valid held high -> 32 consecutive pix_valid=1 cycles, no gap, in correct cell order.
- Out of range: chr_val=0x10 and 0x80 -> rom_addr = REPL_IDX*16 + row; row=16 (ROW_W=5 variant) -> all 8 pixels bg.
- Attributes: cursor=1, cursor_phase=1, ROM 0x18 -> on = 1,1,1,0,0,1,1,1; blink=1, blink_phase=0 -> all bg; phase toggled mid-cell -> no change until next cell.
- Reset mid-cell: rst asserted at 3rd pixel -> pix_valid=0 next cycle; a fresh cell after reset outputs correctly with latency 3.

Source files
------------

// File: rtl/chr_pixel_pipe_if.sv
// Cell-request, glyph-ROM and pixel-output signals of the text-mode pixel pipe.
// The master side is the text scanner together with the ROM. The slave side is the pipe.
interface chr_pixel_pipe_if #(
    parameter int GLYPH_W = 8,
    parameter int COLOR_W = 4,
    parameter int ROW_W   = 4,
    parameter int ADDR_W  = 11
);
    logic               chr_valid;
    logic               chr_ready;
    logic [7:0]         chr_val;
    logic [ROW_W-1:0]   row;
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
    logic               cursor;
    logic               cursor_phase;
    logic               blink;
    logic               blink_phase;
    logic [ADDR_W-1:0]  rom_addr;
    logic [GLYPH_W-1:0] rom_data;
    logic               pix_valid;
    logic               pix_on;
    logic [COLOR_W-1:0] pix_color;

    modport master (
        output chr_valid, chr_val, row, fg, bg, cursor, cursor_phase, blink, blink_phase, rom_data,
        input  chr_ready, rom_addr, pix_valid, pix_on, pix_color
    );
    modport slave (
        input  chr_valid, chr_val, row, fg, bg, cursor, cursor_phase, blink, blink_phase, rom_data,
        output chr_ready, rom_addr, pix_valid, pix_on, pix_color
    );
endinterface

// File: rtl/chr_pixel_pipe.sv
// Glyph fetch and pixel serialiser. A character cell becomes a ROM row address.
// The returned row is shifted out MSB-first as resolved colour indices, one pixel per clock.
module chr_pixel_pipe #(
    parameter int GLYPH_W    = 8,
    parameter int GLYPH_H    = 16,
    parameter int CHAR_BASE  = 32,
    parameter int NUM_GLYPHS = 96,
    parameter int REPL_IDX   = 0,
    parameter int COLOR_W    = 4,
    parameter int ROW_W      = 4,
    parameter int ADDR_W     = $clog2(NUM_GLYPHS*GLYPH_H)
) (
    input logic clk,
    input logic rst,
    chr_pixel_pipe_if.slave bus
);
    localparam int CNT_W = $clog2(GLYPH_W);

    typedef struct packed {
        logic [COLOR_W-1:0] fg;
        logic [COLOR_W-1:0] bg;
        logic               inv;
        logic               kill;
    } attr_t;

    logic               a_valid, a_blank, b_valid, s_valid;
    attr_t              a_attr, b_attr, s_attr;
    logic [GLYPH_W-1:0] b_data, s_data;
    logic [CNT_W-1:0]   s_cnt;
    logic [ADDR_W-1:0]  rom_addr_q, addr_nxt;
    logic               pix_valid_q, pix_on_q, accept, in_range, row_blank, s_last, on;
    logic [COLOR_W-1:0] pix_color_q;
    logic [8:0]         code_off;

    // B must be empty to accept, so an A->B move never meets an S load of B.
    assign bus.chr_ready = !rst && !a_valid && !b_valid;
    assign accept        = bus.chr_valid && bus.chr_ready;

    always_comb begin
        code_off  = {1'b0, bus.chr_val} - 9'(CHAR_BASE);
        in_range  = (int'(bus.chr_val) >= CHAR_BASE) && (int'(bus.chr_val) < CHAR_BASE + NUM_GLYPHS);
        row_blank = int'(bus.row) >= GLYPH_H;
        addr_nxt  = ADDR_W'((in_range ? int'(code_off) : REPL_IDX) * GLYPH_H
                            + (row_blank ? 0 : int'(bus.row)));
    end

    assign s_last = s_cnt == CNT_W'(GLYPH_W - 1);
    assign on     = (s_data[GLYPH_W-1] ^ s_attr.inv) & ~s_attr.kill;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid     <= 1'b0;
            b_valid     <= 1'b0;
            s_valid     <= 1'b0;
            s_cnt       <= '0;
            rom_addr_q  <= '0;
            pix_valid_q <= 1'b0;
            pix_on_q    <= 1'b0;
            pix_color_q <= '0;
        end else begin
            a_valid <= accept;
            if (accept) begin
                rom_addr_q   <= addr_nxt;
                a_blank      <= row_blank;
                a_attr.fg    <= bus.fg;
                a_attr.bg    <= bus.bg;
                a_attr.inv   <= bus.cursor & bus.cursor_phase;
                a_attr.kill  <= bus.blink & ~bus.blink_phase;
            end

            if (!s_valid || s_last) begin
                s_valid <= b_valid;
                if (b_valid) begin
                    s_data  <= b_data;
                    s_attr  <= b_attr;
                    s_cnt   <= '0;
                    b_valid <= 1'b0;
                end
            end else begin
                s_data <= s_data << 1;
                s_cnt  <= s_cnt + CNT_W'(1);
            end

            if (a_valid) begin
                b_valid <= 1'b1;
                b_data  <= a_blank ? '0 : bus.rom_data;
                b_attr  <= a_attr;
            end

            pix_valid_q <= s_valid;
            if (s_valid) begin
                pix_on_q    <= on;
                pix_color_q <= on ? s_attr.fg : s_attr.bg;
            end
        end
    end

    assign bus.rom_addr  = rom_addr_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.pix_on    = pix_on_q;
    assign bus.pix_color = pix_color_q;
endmodule

// File: tb/tb_chr_pixel_pipe.sv
// Bench for chr_pixel_pipe: vector table, hand-written reset/phase sequences,
// and a randomized back-to-back stream checked against a cell-level model.
module tb_chr_pixel_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    chr_pixel_pipe_if #(.GLYPH_W(8), .COLOR_W(4), .ROW_W(5), .ADDR_W(11)) bus ();

    chr_pixel_pipe #(.GLYPH_W(8), .GLYPH_H(16), .CHAR_BASE(32), .NUM_GLYPHS(96),
                     .REPL_IDX(0), .COLOR_W(4), .ROW_W(5), .ADDR_W(11))
        dut (.clk(clk), .rst(rst), .bus(bus));

    logic [7:0] rom_mem [0:2047];
    assign bus.rom_data = rom_mem[bus.rom_addr];

    typedef struct {
        logic [7:0] code;
        logic [4:0] row;
        logic [3:0] fg, bg;
        logic       cur, cph, bl, bph;
        logic [7:0] rom_byte;
        int         exp_addr;
        logic [7:0] exp_on;
        bit         toggle;
    } vec_t;

    int tests = 0;
    int failed = 0;
    vec_t tbl [13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.chr_val      = v.code;
        bus.row          = v.row;
        bus.fg           = v.fg;
        bus.bg           = v.bg;
        bus.cursor       = v.cur;
        bus.cursor_phase = v.cph;
        bus.blink        = v.bl;
        bus.blink_phase  = v.bph;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!bus.chr_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.chr_ready) chk({nm, " ready timeout"}, 32'(bus.chr_ready), 32'd1);
    endtask

    // One cell from idle: address after E0, nothing at E1/E2, 8 pixels after E3..E10, then idle.
    task automatic run_cell(input vec_t v, input string nm);
        logic on;
        rom_mem[v.exp_addr] = v.rom_byte;
        wait_ready(nm);
        drive(v);
        bus.chr_valid = 1'b1;
        tick();
        bus.chr_valid = 1'b0;
        chk({nm, " rom_addr"}, 32'(bus.rom_addr), 32'(v.exp_addr));
        tick();
        tick();
        chk({nm, " latency"}, 32'(bus.pix_valid), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            on = v.exp_on[7-i];
            chk($sformatf("%s pix_valid[%0d]", nm, i), 32'(bus.pix_valid), 32'd1);
            chk($sformatf("%s pix_on[%0d]", nm, i), 32'(bus.pix_on), 32'(on));
            chk($sformatf("%s pix_color[%0d]", nm, i), 32'(bus.pix_color), 32'(on ? v.fg : v.bg));
            if (v.toggle) begin
                bus.cursor_phase = ~bus.cursor_phase;
                bus.blink_phase  = ~bus.blink_phase;
            end
        end
        tick();
        chk({nm, " end idle"}, 32'(bus.pix_valid), 32'd0);
    endtask

    // Cell-level reference for the random stream.
    logic [4:0] exp_q [$];
    task automatic model_cell(input vec_t v);
        int idx, addr;
        bit blank, on;
        logic [7:0] d;
        idx   = (v.code >= 32 && v.code < 128) ? int'(v.code) - 32 : 0;
        blank = v.row >= 16;
        addr  = idx * 16 + (blank ? 0 : int'(v.row));
        d     = blank ? 8'h00 : rom_mem[addr];
        for (int i = 0; i < 8; i++) begin
            on = d[7-i] ^ (v.cur & v.cph);
            if (v.bl && !v.bph) on = 1'b0;
            exp_q.push_back({on, on ? v.fg : v.bg});
        end
    endtask

    bit mon_en = 0;
    bit started = 0;
    int gaps = 0;
    int pix_seen = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.pix_valid) begin
                logic [4:0] e;
                started = 1;
                pix_seen++;
                if (exp_q.size() == 0) begin
                    chk("stream extra pixel", 32'(pix_seen), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream pixel", {27'd0, bus.pix_on, bus.pix_color}, 32'(e));
                end
            end else if (started && exp_q.size() > 0) begin
                gaps++;
            end
        end
    end

    initial begin
        vec_t v;
        int sent, guard;
        for (int i = 0; i < 2048; i++) rom_mem[i] = 8'($urandom);
        //         code   row    fg     bg    cur   cph   bl    bph   rom    addr  on      tgl
        tbl[0]  = '{8'h41, 5'd5, 4'hF, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h18, 533,  8'h18, 1'b0};
        tbl[1]  = '{8'h10, 5'd3, 4'h7, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 3,    8'hA5, 1'b0};
        tbl[2]  = '{8'h80, 5'd9, 4'hC, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 9,    8'h3C, 1'b0};
        tbl[3]  = '{8'h41, 5'd16,4'hE, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 528,  8'h00, 1'b0};
        tbl[4]  = '{8'h41, 5'd5, 4'hA, 4'h6, 1'b1, 1'b1, 1'b0, 1'b0, 8'h18, 533,  8'hE7, 1'b0};
        tbl[5]  = '{8'h41, 5'd5, 4'hB, 4'h4, 1'b0, 1'b0, 1'b1, 1'b0, 8'h18, 533,  8'h00, 1'b0};
        tbl[6]  = '{8'h41, 5'd5, 4'h9, 4'h2, 1'b0, 1'b0, 1'b1, 1'b1, 8'h18, 533,  8'h18, 1'b0};
        tbl[7]  = '{8'h41, 5'd5, 4'h8, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h18, 533,  8'h18, 1'b0};
        tbl[8]  = '{8'h20, 5'd0, 4'h3, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0, 8'h81, 0,    8'h81, 1'b0};
        tbl[9]  = '{8'h7F, 5'd15,4'h5, 4'hA, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1535, 8'h5A, 1'b0};
        tbl[10] = '{8'hFF, 5'd2, 4'h6, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42, 2,    8'h42, 1'b0};
        tbl[11] = '{8'h41, 5'd5, 4'h7, 4'h8, 1'b1, 1'b1, 1'b1, 1'b0, 8'h18, 533,  8'h00, 1'b0};
        tbl[12] = '{8'h41, 5'd5, 4'hD, 4'h2, 1'b1, 1'b0, 1'b1, 1'b1, 8'h18, 533,  8'h18, 1'b1};

        bus.chr_valid = 1'b0;
        drive(tbl[0]);
        rst = 1'b1;
        repeat (3) tick();
        chk("reset pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("reset pix_on", 32'(bus.pix_on), 32'd0);
        chk("reset pix_color", 32'(bus.pix_color), 32'd0);
        chk("reset rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("reset chr_ready", 32'(bus.chr_ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready after reset", 32'(bus.chr_ready), 32'd1);
        tick();

        for (int i = 0; i < 13; i++) run_cell(tbl[i], $sformatf("vec%0d", i));

        // Reset while the third pixel is on the outputs aborts the cell.
        rom_mem[533] = 8'h18;
        wait_ready("abort");
        drive(tbl[0]);
        bus.chr_valid = 1'b1;
        tick();
        bus.chr_valid = 1'b0;
        repeat (5) tick();
        chk("abort pixel3 valid", 32'(bus.pix_valid), 32'd1);
        chk("abort pixel3 on", 32'(bus.pix_on), 32'd0);
        rst = 1'b1;
        tick();
        chk("abort pix_valid", 32'(bus.pix_valid), 32'd0);
        chk("abort chr_ready", 32'(bus.chr_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort no pixels", 32'(bus.pix_valid), 32'd0);
        end
        run_cell(tbl[0], "post-abort");

        // Randomized back-to-back stream with chr_valid held high.
        mon_en = 1;
        sent = 0;
        guard = 0;
        v = tbl[0];
        v.toggle = 1'b0;
        v.code = 8'($urandom_range(0, 255)); v.row = 5'($urandom_range(0, 17));
        v.fg = 4'($urandom); v.bg = 4'($urandom);
        v.cur = 1'($urandom); v.cph = 1'($urandom); v.bl = 1'($urandom); v.bph = 1'($urandom);
        drive(v);
        bus.chr_valid = 1'b1;
        while (sent < 24 && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (bus.chr_ready) begin
                model_cell(v);
                sent++;
                @(posedge clk);
                #1;
                if (sent < 24) begin
                    v.code = 8'($urandom_range(0, 255)); v.row = 5'($urandom_range(0, 17));
                    v.fg = 4'($urandom); v.bg = 4'($urandom);
                    v.cur = 1'($urandom); v.cph = 1'($urandom);
                    v.bl = 1'($urandom); v.bph = 1'($urandom);
                    drive(v);
                end else begin
                    bus.chr_valid = 1'b0;
                end
            end
        end
        bus.chr_valid = 1'b0;
        chk("stream cells sent", 32'(sent), 32'd24);
        guard = 0;
        while (exp_q.size() > 0 && guard < 400) begin
            tick();
            guard++;
        end
        repeat (3) tick();
        mon_en = 0;
        chk("stream drained", 32'(exp_q.size()), 32'd0);
        chk("stream pixel count", 32'(pix_seen), 32'(24 * 8));
        chk("stream gaps", 32'(gaps), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
